// File: rtl/decimal_pkg.sv
// Shared constants for the decimal conversion path: BCD digit geometry,
// reverse double-dabble correction values and converter state encoding.
package decimal_pkg;

  localparam int unsigned BCD_DIG_W       = 4;
  localparam logic [3:0]  BCD_CORR_THRESH = 4'd8;
  localparam logic [3:0]  BCD_CORR_VAL    = 4'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StShift  = ST_SHIFT,
    StFinish = ST_FINISH
  } state_e;

  function automatic logic bcd_digit_bad(input logic [3:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_sub3_4bit.sv
// Reverse double-dabble correction cell: subtracts 3 from a BCD digit that
// reached 8 or more after a right shift (mirror of the add-3 cell).
module bcd_sub3_4bit
  import decimal_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o,
  output logic       ge8_o
);

  always_comb begin
    ge8_o   = digit_i >= BCD_CORR_THRESH;
    digit_o = ge8_o ? (digit_i - BCD_CORR_VAL) : digit_i;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one right shift per clock with
// per-digit subtract-3 correction, BIN_W shifts per conversion.
module bcd_to_bin_seq
  import decimal_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned BIN_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIG-1:0]      bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic [BIN_W-1:0]       bin_out,
  output logic                   err
);

  localparam int unsigned SregW = BCD_DIG_W * NDIG + BIN_W;
  localparam int unsigned CntW  = $clog2(BIN_W);
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

  state_e            state_q, state_d;
  logic [SregW-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;

  logic [SregW-1:0]          shifted, corrected;
  logic [NDIG-1:0][3:0]      sub_dig;
  logic [NDIG-1:0]           sub_ge8;
  logic                      in_bad;

  assign shifted = sreg_q >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : gen_corr
    bcd_sub3_4bit u_sub3 (
      .digit_i (shifted[BIN_W + g*BCD_DIG_W +: BCD_DIG_W]),
      .digit_o (sub_dig[g]),
      .ge8_o   (sub_ge8[g])
    );
  end

  always_comb begin
    corrected = shifted;
    for (int i = 0; i < NDIG; i++) begin
      if (sub_ge8[i]) corrected[BIN_W + i*BCD_DIG_W +: BCD_DIG_W] = sub_dig[i];
    end
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      in_bad = in_bad | bcd_digit_bad(bcd_in[i*BCD_DIG_W +: BCD_DIG_W]);
    end
  end

  // Result registers load on the last shift so they are valid while FINISH drives done.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sreg_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          bad_d   = in_bad;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        sreg_d = corrected;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFinish;
          done_d  = 1'b1;
          bin_d   = bad_q ? '0 : corrected[BIN_W-1:0];
          err_d   = bad_q;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;

  // Valid BCD must be fully drained out of the digit field by the last shift.
  a_bcd_drained: assert property (@(posedge clk) disable iff (rst)
    (state_q == StShift && cnt_q == CntLast && !bad_q) |-> (corrected[SregW-1:BIN_W] == '0));

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: vector table run back-to-back, plus
// reset-abort and start-toggling sequences.
module tb_bcd_to_bin_seq;

  localparam int LAT  = 15;  // negedges after the accept edge until done is seen
  localparam int BUSY = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_to_bin_seq #(.NDIG(4), .BIN_W(14)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
    int          exp_err;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called just after a negedge; returns after the 16th negedge (first IDLE cycle).
  task automatic do_conv(input logic [15:0] bcd, input bit toggle,
                         output int b, output int e, output int lat,
                         output int busy_cnt, output int done_cnt);
    b = -1; e = -1; lat = -1; busy_cnt = 0; done_cnt = 0;
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk);
    #1 start = 1'b0;
    if (toggle) bcd_in = 16'h9999;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = cyc;
          b   = int'(bin_out);
          e   = int'(err);
        end
      end
      if (toggle && cyc < 16) start = ~start;
    end
    start = 1'b0;
  endtask

  task automatic check_conv(input string nm, input logic [15:0] bcd, input bit toggle,
                            input int exp_bin, input int exp_err);
    int b, e, lat, bc, dc;
    do_conv(bcd, toggle, b, e, lat, bc, dc);
    check({nm, ".bin"}, b, exp_bin);
    check({nm, ".err"}, e, exp_err);
    check({nm, ".lat"}, lat, LAT);
    check({nm, ".busy_cycles"}, bc, BUSY);
    check({nm, ".done_count"}, dc, 1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h0000,    0, 0};
    vecs[1] = '{16'h9999, 9999, 0};
    vecs[2] = '{16'h1234, 1234, 0};
    vecs[3] = '{16'h0255,  255, 0};
    vecs[4] = '{16'h12A4,    0, 1};
    vecs[5] = '{16'h0007,    7, 0};
    vecs[6] = '{16'h8000, 8000, 0};
    vecs[7] = '{16'h0F00,    0, 1};
    vecs[8] = '{16'h4096, 4096, 0};
    vecs[9] = '{16'h0010,   10, 0};

    rst = 1'b1; start = 1'b0; bcd_in = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.bin",  int'(bin_out), 0);
    check("reset.err",  int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each conversion starts in the first IDLE cycle after done.
    for (int i = 0; i < 10; i++) begin
      check_conv($sformatf("vec%0d_%h", i, vecs[i].bcd), vecs[i].bcd, 1'b0,
                 vecs[i].exp_bin, vecs[i].exp_err);
    end

    // Reset mid-conversion aborts with no done pulse.
    begin
      int dc;
      start = 1'b1; bcd_in = 16'h5000;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort.busy", int'(busy), 0);
      check("abort.done", int'(done), 0);
      check("abort.bin",  int'(bin_out), 0);
      check("abort.err",  int'(err), 0);
      @(negedge clk);
      rst = 1'b0;
      dc = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        if (done || busy) dc++;
      end
      check("abort.no_done", dc, 0);
      check_conv("after_abort", 16'h0042, 1'b0, 42, 0);
    end

    // start toggled and bcd_in changed throughout a conversion.
    check_conv("toggle", 16'h0100, 1'b1, 100, 0);
    begin
      int dc;
      dc = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        if (done) dc++;
      end
      check("toggle.no_extra_done", dc, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
